joy_db15_tx: RTL and testbench
==============================

# joy_db15_tx

Synthesizable emulation of the DB15 joystick adapter's parallel-in/serial-out shift chain: the device end of the JOY_CLK / JOY_LOAD / JOY_DATA protocol that joy_db15 drives as master. The block accepts two players' button words, latches them while the master holds JOY_LOAD low, and shifts one bit onto JOY_DATA per JOY_CLK rising edge. It serves as a loopback target on the UserIO port for board bring-up and as a bit-exact stimulus source for the receiver's bench.

## Interface
- WIDTH, 12: bits per player. Bit order is R,L,D,U,A,B,C,D,E,F,S,L (bit 0 first).
- clk  in  1  system clock (40-50 MHz, same domain as CLK_JOY).
- reset  in  1  synchronous, active-high.
- joystick1  in  WIDTH  player 1 buttons, 1 = pressed.
- joystick2  in  WIDTH  player 2 buttons, 1 = pressed.
- JOY_CLK  in  1  shift clock from the master; asynchronous to clk.
- JOY_LOAD  in  1  active-low parallel load from the master; asynchronous to clk.
- JOY_DATA  out  1  serial data, active-low (0 = pressed). Registered.
- frame_stb  out  1  one-clk pulse when the last chain bit has been presented.
- busy  out  1  high from load release until the frame completes.

## Operation
- JOY_CLK and JOY_LOAD each pass through a 2-flop synchronizer and then an edge-detect register.
- Chain: 2*WIDTH-bit register ordered {joystick2, joystick1}. joystick1[0] is presented first.
- Load: while synchronized JOY_LOAD = 0, the chain reloads from the inputs every clk, cnt = 0, and JOY_DATA = ~joystick1[0]. Load is transparent, as on the 74HC165.
- Shift: on a synchronized JOY_CLK rising edge with JOY_LOAD = 1 and cnt < 2*WIDTH:
  - the chain shifts right and a 0 (released) fills the top;
  - cnt increments;
  - JOY_DATA takes the next bit, inverted.
- When cnt reaches 2*WIDTH, frame_stb pulses for one cycle. Further shifts present JOY_DATA = 1 (idle fill); cnt saturates.
- busy = JOY_LOAD synced high && cnt < 2*WIDTH.
- Simultaneous load low and clock edge in the same cycle: load wins and no shift occurs.
- JOY_CLK edges arriving while load is low are ignored.
- Reset, including mid-frame: chain = all released, cnt = 0, JOY_DATA = 1, frame_stb = 0, busy = 0, synchronizer/edge flops = 1 (no spurious edge after reset). The next frame needs a fresh load.
- cnt is $clog2(2*WIDTH+1) bits wide and never wraps.

## Timing
- JOY_CLK rise to JOY_DATA update: 3 clk edges after the first edge that samples the new level (sync, sync, shift register). With the filter, 5 edges.
- JOY_LOAD fall to first bit valid: 3 clk edges. Input changes during load are visible on JOY_DATA 1 edge later.
- frame_stb is asserted in the same cycle JOY_DATA presents bit 2*WIDTH-1's successor, i.e. the cycle after the final shift.
- Master JOY_CLK high and low phases must each be at least 3 clk periods (5 with the filter).

## Configuration
- JOY_DB15_TX_FILTER_EN defined:
  - each synchronized JOY_CLK / JOY_LOAD level must be stable for 2 consecutive clk cycles before it is accepted;
  - a shorter pulse is dropped and causes no shift or load;
  - latency +2 clk.
- Undefined: synchronizer output is used directly, and a pulse of at least 2 clk is accepted.

## Test plan
- Reset then idle, no stimulus -> JOY_DATA = 1, busy = 0, frame_stb = 0 for 100 cycles.
- joystick1 = 12'h001, joystick2 = 12'h800, load pulse, then 24 clocks (period 20 clk) -> JOY_DATA sequence 0, then 22 ones, then 0 last. frame_stb fires once after the 24th shift.
- Same frame followed by 4 extra clocks -> JOY_DATA stays 1, cnt stays 24, no second frame_stb.
- joystick1 = 12'hFFF, 10 shifts, then reset asserted for 1 cycle -> JOY_DATA = 1 next cycle and busy = 0. A following load and shift restarts at joystick1[0].
- JOY_LOAD driven low in the same clk as a JOY_CLK rise, with joystick1 = 12'h002 -> no shift, JOY_DATA = 1 (bit 0 released). After the load is released and one clock, JOY_DATA = 0.
- With JOY_DB15_TX_FILTER_EN: a 1-clk JOY_CLK glitch -> no shift. A 3-clk pulse -> exactly one shift, with JOY_DATA updated 5 edges after the rise.

Source files
------------

// File: rtl/joy_db15_tx.sv
// Device end of the DB15 JOY_CLK/JOY_LOAD/JOY_DATA shift chain (74HC165-style PISO emulation).
// Optional JOY_DB15_TX_FILTER_EN: synchronized levels must hold 2 clk before acceptance (+2 clk latency).
module joy_db15_tx #(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] joystick1,
    input  logic [WIDTH-1:0] joystick2,
    input  logic             JOY_CLK,
    input  logic             JOY_LOAD,
    output logic             JOY_DATA,
    output logic             frame_stb,
    output logic             busy
);

    localparam int CHAIN = 2 * WIDTH;
    localparam int CW    = $clog2(CHAIN + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(CHAIN);
    localparam logic [CW-1:0] CNT_LAST = CW'(CHAIN - 1);

    logic             jclk_s1_q, jclk_s1_d, jclk_s2_q, jclk_s2_d;
    logic             jload_s1_q, jload_s1_d, jload_s2_q, jload_s2_d;
    logic             jclk_prev_q, jclk_prev_d;
    logic [CHAIN-1:0] chain_q, chain_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             data_q, data_d;
    logic             stb_q, stb_d;
    logic             armed_q, armed_d;
    logic             clk_lvl, load_lvl, clk_rise;

`ifdef JOY_DB15_TX_FILTER_EN
    logic jclk_f_q, jclk_f_d, jclk_pend_q, jclk_pend_d;
    logic jload_f_q, jload_f_d, jload_pend_q, jload_pend_d;
`endif

    always_comb begin
        jclk_s1_d  = JOY_CLK;
        jclk_s2_d  = jclk_s1_q;
        jload_s1_d = JOY_LOAD;
        jload_s2_d = jload_s1_q;
`ifdef JOY_DB15_TX_FILTER_EN
        // A mismatch must be seen on two consecutive cycles before the level flips.
        jclk_f_d     = jclk_f_q;
        jclk_pend_d  = 1'b0;
        if (jclk_s2_q != jclk_f_q) begin
            if (jclk_pend_q) jclk_f_d = jclk_s2_q;
            else             jclk_pend_d = 1'b1;
        end
        jload_f_d    = jload_f_q;
        jload_pend_d = 1'b0;
        if (jload_s2_q != jload_f_q) begin
            if (jload_pend_q) jload_f_d = jload_s2_q;
            else              jload_pend_d = 1'b1;
        end
        clk_lvl  = jclk_f_q;
        load_lvl = jload_f_q;
`else
        clk_lvl  = jclk_s2_q;
        load_lvl = jload_s2_q;
`endif
        jclk_prev_d = clk_lvl;
        clk_rise    = clk_lvl & ~jclk_prev_q;

        chain_d = chain_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        armed_d = armed_q;
        stb_d   = 1'b0;

        // Load has priority over a coincident clock edge, and edges during load are ignored.
        if (!load_lvl) begin
            chain_d = {joystick2, joystick1};
            cnt_d   = '0;
            data_d  = ~joystick1[0];
            armed_d = 1'b1;
        end else if (clk_rise && armed_q && (cnt_q < CNT_MAX)) begin
            chain_d = {1'b0, chain_q[CHAIN-1:1]};
            cnt_d   = cnt_q + CW'(1);
            data_d  = ~chain_q[1];
            stb_d   = (cnt_q == CNT_LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            jclk_s1_q   <= 1'b1;
            jclk_s2_q   <= 1'b1;
            jload_s1_q  <= 1'b1;
            jload_s2_q  <= 1'b1;
            jclk_prev_q <= 1'b1;
            chain_q     <= '0;
            cnt_q       <= '0;
            data_q      <= 1'b1;
            stb_q       <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            jclk_s1_q   <= jclk_s1_d;
            jclk_s2_q   <= jclk_s2_d;
            jload_s1_q  <= jload_s1_d;
            jload_s2_q  <= jload_s2_d;
            jclk_prev_q <= jclk_prev_d;
            chain_q     <= chain_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            stb_q       <= stb_d;
            armed_q     <= armed_d;
        end
    end

`ifdef JOY_DB15_TX_FILTER_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            jclk_f_q     <= 1'b1;
            jclk_pend_q  <= 1'b0;
            jload_f_q    <= 1'b1;
            jload_pend_q <= 1'b0;
        end else begin
            jclk_f_q     <= jclk_f_d;
            jclk_pend_q  <= jclk_pend_d;
            jload_f_q    <= jload_f_d;
            jload_pend_q <= jload_pend_d;
        end
    end
`endif

    // Busy needs a load since reset, so a reset mid-frame does not look like a live frame.
    assign busy      = armed_q && load_lvl && (cnt_q < CNT_MAX);
    assign JOY_DATA  = data_q;
    assign frame_stb = stb_q;

endmodule

// File: tb/tb_joy_db15_tx.sv
// Bench for joy_db15_tx: directed protocol steps plus random button frames vs. a serial-stream model.
module tb_joy_db15_tx;

`ifdef JOY_DB15_TX_FILTER_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 3;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] joystick1, joystick2;
    logic        JOY_CLK, JOY_LOAD;
    logic        JOY_DATA, frame_stb, busy;

    int n_tests = 0;
    int n_fail  = 0;
    int stb_cnt = 0;
    int stb_base;
    logic exp_ser[$];

    joy_db15_tx #(.WIDTH(12)) dut (
        .clk       (clk),
        .reset     (reset),
        .joystick1 (joystick1),
        .joystick2 (joystick2),
        .JOY_CLK   (JOY_CLK),
        .JOY_LOAD  (JOY_LOAD),
        .JOY_DATA  (JOY_DATA),
        .frame_stb (frame_stb),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (frame_stb) stb_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Expected wire stream: player 1 buttons in order, then player 2, active-low, then idle ones.
    task automatic build_exp(input logic [11:0] p1, input logic [11:0] p2);
        exp_ser.delete();
        for (int b = 0; b < 12; b++) exp_ser.push_back(!p1[b]);
        for (int b = 0; b < 12; b++) exp_ser.push_back(!p2[b]);
        repeat (6) exp_ser.push_back(1'b1);
    endtask

    task automatic shift_one();
        JOY_CLK = 1'b1;
        tick(10);
        JOY_CLK = 1'b0;
        tick(10);
    endtask

    task automatic do_load(input logic [11:0] p1, input logic [11:0] p2);
        joystick1 = p1;
        joystick2 = p2;
        JOY_LOAD  = 1'b0;
        tick(LAT + 3);
        JOY_LOAD  = 1'b1;
        tick(LAT + 3);
        check("load_bit0", 32'(JOY_DATA), 32'(exp_ser[0]));
        check("load_busy", 32'(busy), 32'd1);
    endtask

    task automatic run_shifts(input string tag, input int from, input int to);
        for (int k = from; k <= to; k++) begin
            shift_one();
            check({tag, "_data"}, 32'(JOY_DATA), 32'(exp_ser[k]));
            check({tag, "_busy"}, 32'(busy), 32'(k < 24));
        end
    endtask

    initial begin
        reset     = 1'b1;
        joystick1 = '0;
        joystick2 = '0;
        JOY_CLK   = 1'b0;
        JOY_LOAD  = 1'b1;
        tick(3);
        check("rst_data", 32'(JOY_DATA), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_stb", 32'(frame_stb), 32'd0);
        reset = 1'b0;

        // Idle with no stimulus
        for (int i = 0; i < 100; i++) begin
            tick(1);
            check("idle_data", 32'(JOY_DATA), 32'd1);
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_stb", 32'(frame_stb), 32'd0);
        end

        // Directed frame 001/800 with load and shift latency checks
        build_exp(12'h001, 12'h800);
        joystick1 = 12'h001;
        joystick2 = 12'h800;
        stb_base  = stb_cnt;
        JOY_LOAD  = 1'b0;
        repeat (LAT - 1) @(posedge clk);
        #1;
        check("load_lat_before", 32'(JOY_DATA), 32'd1);
        tick(1);
        check("load_lat_at", 32'(JOY_DATA), 32'd0);
        joystick1 = 12'h000;
        tick(1);
        check("load_transparent_a", 32'(JOY_DATA), 32'd1);
        joystick1 = 12'h001;
        tick(1);
        check("load_transparent_b", 32'(JOY_DATA), 32'd0);
        JOY_LOAD = 1'b1;
        tick(LAT + 3);
        check("f1_bit0", 32'(JOY_DATA), 32'(exp_ser[0]));
        check("f1_busy", 32'(busy), 32'd1);
        JOY_CLK = 1'b1;
        repeat (LAT - 1) @(posedge clk);
        #1;
        check("shift_lat_before", 32'(JOY_DATA), 32'(exp_ser[0]));
        tick(1);
        check("shift_lat_at", 32'(JOY_DATA), 32'(exp_ser[1]));
        tick(10 - LAT);
        JOY_CLK = 1'b0;
        tick(10);
        run_shifts("f1", 2, 24);
        check("f1_stb_once", 32'(stb_cnt - stb_base), 32'd1);
        run_shifts("f1_extra", 25, 28);
        check("f1_stb_no_second", 32'(stb_cnt - stb_base), 32'd1);

        // Reset in the middle of a frame
        build_exp(12'hFFF, 12'h3C3);
        do_load(12'hFFF, 12'h3C3);
        run_shifts("f2", 1, 10);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("midrst_data", 32'(JOY_DATA), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        shift_one();
        check("midrst_noshift_data", 32'(JOY_DATA), 32'd1);
        check("midrst_noshift_busy", 32'(busy), 32'd0);
        build_exp(12'h5A5, 12'h0F0);
        do_load(12'h5A5, 12'h0F0);
        run_shifts("f3", 1, 3);

        // Load falling together with a clock rise: load wins
        build_exp(12'h00A, 12'h000);
        joystick1 = 12'h00A;
        joystick2 = 12'h000;
        JOY_CLK   = 1'b1;
        JOY_LOAD  = 1'b0;
        tick(LAT + 3);
        check("coinc_data", 32'(JOY_DATA), 32'(exp_ser[0]));
        check("coinc_busy", 32'(busy), 32'd0);
        JOY_LOAD = 1'b1;
        tick(LAT + 3);
        check("coinc_rel_data", 32'(JOY_DATA), 32'(exp_ser[0]));
        JOY_CLK = 1'b0;
        tick(10);
        JOY_CLK = 1'b1;
        tick(10);
        check("coinc_shift", 32'(JOY_DATA), 32'(exp_ser[1]));
        JOY_CLK = 1'b0;
        tick(10);

`ifdef JOY_DB15_TX_FILTER_EN
        JOY_CLK = 1'b1;
        tick(1);
        JOY_CLK = 1'b0;
        tick(10);
        check("glitch_dropped", 32'(JOY_DATA), 32'(exp_ser[1]));
        JOY_CLK = 1'b1;
        tick(3);
        JOY_CLK = 1'b0;
        check("pulse3_e3", 32'(JOY_DATA), 32'(exp_ser[1]));
        tick(1);
        check("pulse3_e4", 32'(JOY_DATA), 32'(exp_ser[1]));
        tick(1);
        check("pulse3_e5", 32'(JOY_DATA), 32'(exp_ser[2]));
        tick(10);
        check("pulse3_single", 32'(JOY_DATA), 32'(exp_ser[2]));
`else
        JOY_CLK = 1'b1;
        tick(2);
        JOY_CLK = 1'b0;
        tick(10);
        check("pulse2_shift", 32'(JOY_DATA), 32'(exp_ser[2]));
        tick(10);
        check("pulse2_single", 32'(JOY_DATA), 32'(exp_ser[2]));
`endif

        // Random button words
        for (int f = 0; f < 5; f++) begin
            logic [11:0] r1, r2;
            r1 = 12'($urandom);
            r2 = 12'($urandom);
            build_exp(r1, r2);
            stb_base = stb_cnt;
            do_load(r1, r2);
            run_shifts("rnd", 1, 24 + int'($urandom_range(1, 4)));
            check("rnd_stb_once", 32'(stb_cnt - stb_base), 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
